uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default sizing for the UART transmit feeder.
//   tx_state_e           - feeder FSM state encoding (2 bits)
//   UART_DEPTH_DEFAULT   - default FIFO depth in bytes
//   UART_TIMEOUT_DEFAULT - default cycles to wait for txdone per byte
//   UART_BYTE_W          - width of one queued byte
package uart_pkg;

  localparam int unsigned UART_DEPTH_DEFAULT   = 16;
  localparam int unsigned UART_TIMEOUT_DEFAULT = 64;
  localparam int unsigned UART_BYTE_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: register-array byte FIFO with count, full and empty flags.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write wr_data at this edge (ignored while full)
//   wr_data     - byte to store
//   pop         - advance the read pointer at this edge (ignored while empty)
//   rd_data     - head byte (combinational view of the entry at the read pointer)
//   count       - bytes currently stored
//   full, empty - occupancy flags derived from count
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [UART_BYTE_W-1:0]   wr_data,
  input  logic                     pop,
  output logic [UART_BYTE_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues bytes from a producer and hands them one at a time to
// an 8N1 transmitter, with a per-byte completion timeout and sticky errors.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_data, wr_valid  - producer byte offer
//   wr_ready           - FIFO can accept (combinational, count < DEPTH)
//   txbyte, senddata   - byte and one-cycle trigger to the transmitter
//   txdone             - transmitter completion pulse
//   fifo_count         - bytes queued
//   busy               - FSM active or bytes queued
//   err_clr            - clears sticky errors (a same-cycle set wins)
//   overflow, tmo_err  - sticky: write while full, txdone timeout
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = UART_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT = UART_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [7:0]             txbyte,
  output logic                   senddata,
  input  logic                   txdone,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   tmo_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic [TW-1:0]          tmo_cnt_q;
  logic [TW-1:0]          tmo_cnt_d;
  logic                   push;
  logic                   pop;
  logic                   tmo_hit;
  logic                   tmo_set;
  logic                   ovf_set;
  logic [UART_BYTE_W-1:0] head;
  logic                   fifo_full;
  logic                   fifo_empty;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Full refuses a write even when a pop lands on the same edge.
  assign wr_ready = ~fifo_full;
  assign push     = wr_valid & wr_ready;
  assign ovf_set  = wr_valid & ~wr_ready;
  assign tmo_hit  = (state_q == S_WAIT) && (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign busy     = (state_q != S_IDLE) || (fifo_count != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; txdone only matters while waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (txdone || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop the head when leaving idle, run the wait timer.
  always_comb begin
    pop       = 1'b0;
    tmo_set   = 1'b0;
    tmo_cnt_d = '0;
    unique case (state_q)
      S_IDLE: pop = ~fifo_empty;
      S_WAIT: begin
        if (!txdone) begin
          if (tmo_hit) begin
            tmo_set = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; senddata follows the pop so it is high for the S_SEND cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txbyte    <= '0;
      senddata  <= 1'b0;
      tmo_cnt_q <= '0;
      overflow  <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      if (pop) begin
        txbyte <= head;
      end
      senddata  <= pop;
      tmo_cnt_q <= tmo_cnt_d;
      overflow  <= ovf_set | (overflow & ~err_clr);
      tmo_err   <= tmo_set | (tmo_err & ~err_clr);
    end
  end

endmodule
